// File: rtl/reply_encoder_if.sv
// rtl/reply_encoder_if.sv - source-side and transmit-side byte handshakes of the reply encoder
`ifndef N_SRC
`define N_SRC 4
`endif
`ifndef PREFIX
`define PREFIX 8'hAA
`endif

interface reply_encoder_if #(
  parameter int N_SRC = `N_SRC
);
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_valid;
  logic [N_SRC-1:0]   src_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  // Encoder side: consumes source lanes, produces the framed byte stream.
  modport slave (
    input  src_data, src_valid, tx_ready,
    output src_ready, tx_data, tx_valid
  );

  // Environment side: drives source lanes and the transmitter's ready.
  modport master (
    output src_data, src_valid, tx_ready,
    input  src_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/reply_encoder.sv
// rtl/reply_encoder.sv - round-robin message collector and PREFIX/SRC/LEN/DATA/CRC framer
`ifndef N_SRC
`define N_SRC 4
`endif
`ifndef PREFIX
`define PREFIX 8'hAA
`endif

module reply_encoder #(
  parameter int         N_SRC  = `N_SRC,
  parameter logic [7:0] PREFIX = `PREFIX
) (
  input  logic           clk,
  input  logic           n_rst,
  reply_encoder_if.slave bus,
  output logic           busy
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {
    IDLE, COLLECT, SEND_PREFIX, SEND_SRC, SEND_LEN, SEND_DATA, SEND_CRC
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] sel, rr_ptr, pick;
  logic          found;
  logic [7:0]    len, rd_ptr, crc, lane;
  logic [7:0]    mem [0:254];
  logic          accept, tx_fire;

  assign lane    = bus.src_data[int'(sel)*8 +: 8];
  assign accept  = (state == COLLECT) && bus.src_valid[sel];
  assign tx_fire = bus.tx_valid && bus.tx_ready;
  assign busy    = (state != IDLE);

  // First requesting source at or after rr_ptr, wrapping at N_SRC.
  always_comb begin : rr_search
    int j;
    pick  = rr_ptr;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_SRC; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_SRC) j = j - N_SRC;
      if (!found && bus.src_valid[j]) begin
        found = 1'b1;
        pick  = SW'(j);
      end
    end
  end

  // Next-state decode: collect until the source drops or the buffer fills, then frame it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (found) state_next = COLLECT;
      COLLECT: begin
        if (accept) begin
          if (len == 8'd254) state_next = SEND_PREFIX;
        end else if (len != 8'd0) begin
          state_next = SEND_PREFIX;
        end else begin
          state_next = IDLE;
        end
      end
      SEND_PREFIX: if (tx_fire) state_next = SEND_SRC;
      SEND_SRC:    if (tx_fire) state_next = SEND_LEN;
      SEND_LEN:    if (tx_fire) state_next = SEND_DATA;
      SEND_DATA:   if (tx_fire && (rd_ptr == len - 8'd1)) state_next = SEND_CRC;
      SEND_CRC:    if (tx_fire) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Outputs decoded from registers only, so no input reaches an output combinationally.
  always_comb begin
    bus.src_ready = '0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    case (state)
      COLLECT:     bus.src_ready = N_SRC'(1) << sel;
      SEND_PREFIX: begin bus.tx_valid = 1'b1; bus.tx_data = PREFIX;             end
      SEND_SRC:    begin bus.tx_valid = 1'b1; bus.tx_data = 8'(sel);            end
      SEND_LEN:    begin bus.tx_valid = 1'b1; bus.tx_data = len;                end
      SEND_DATA:   begin bus.tx_valid = 1'b1; bus.tx_data = mem[rd_ptr];        end
      SEND_CRC:    begin bus.tx_valid = 1'b1; bus.tx_data = crc + 8'(sel) + len; end
      default:     ;
    endcase
  end

  // State register plus selection, length, read pointer and running data sum.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
      len    <= 8'd0;
      rd_ptr <= 8'd0;
      crc    <= 8'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (found) begin
          sel    <= pick;
          len    <= 8'd0;
          rd_ptr <= 8'd0;
          crc    <= 8'd0;
        end
        COLLECT: if (accept) begin
          len <= len + 8'd1;
          crc <= crc + lane;
        end
        SEND_DATA: if (tx_fire) rd_ptr <= rd_ptr + 8'd1;
        SEND_CRC:  if (tx_fire) rr_ptr <= (sel == SW'(N_SRC - 1)) ? '0 : sel + 1'b1;
        default: ;
      endcase
    end
  end

  // Message buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) mem[len] <= lane;
  end

endmodule

// File: doc/reply_encoder.md
# reply_encoder

Transmit-side counterpart of the command decoder. It collects a byte stream from one of N_SRC internal sources and frames it as PREFIX, SRC, LEN, DATA…, CRC. The framed bytes go out on a valid/ready byte interface toward the UART/USB transmitter. Sources are served round-robin, and each message is buffered whole so LEN can be sent before the data.

## Interface
- N_SRC, default `N_SRC: number of sources, up to 256.
- PREFIX, default `PREFIX: frame start byte.
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- src_data  in  8*N_SRC  packed source bytes; source i occupies [8i+7:8i].
- src_valid  in  N_SRC  source i has a byte on its lane.
- src_ready  out  N_SRC  one-hot grant; a byte is accepted when src_valid[i] & src_ready[i].
- tx_data  out  8  framed output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts; a byte moves on tx_valid & tx_ready.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Internal 255×8 buffer with wr_ptr, rd_ptr and an 8-bit len counter; sel register holds the current source index; rr_ptr register holds the round-robin pointer.
- States: IDLE, COLLECT, SEND_PREFIX, SEND_SRC, SEND_LEN, SEND_DATA, SEND_CRC.
- IDLE:
  - If any src_valid is high, sel takes the first valid index searching upward from rr_ptr, modulo N_SRC.
  - Then go to COLLECT, with len=0 and crc=0.
- COLLECT:
  - src_ready = 1 << sel.
  - Each accepted byte is written to buf[len], len increments, and crc += byte.
  - Exits:
    - Byte accepted while len==254: the 255th byte is stored and the state goes to SEND_PREFIX.
    - src_valid[sel] low with len>0: go to SEND_PREFIX.
    - src_valid[sel] low with len==0: abandon, return to IDLE, nothing transmitted, rr_ptr unchanged.
- SEND_PREFIX outputs PREFIX, then SEND_SRC outputs {zero-pad, sel}, then SEND_LEN outputs len, then SEND_DATA outputs buf[rd_ptr] for rd_ptr 0..len-1, then SEND_CRC.
- Each send state advances only on tx_valid & tx_ready.
- CRC: 8-bit sum modulo 256 of SRC, LEN and all data bytes. PREFIX is excluded. This matches the decoder's check.
- SEND_CRC outputs crc + sel + len (8-bit wrap). On transfer: rr_ptr = (sel+1) mod N_SRC, then go to IDLE.
- src_ready is 0 in every state except COLLECT.
- Reset mid-operation discards all buffered bytes and the partial frame. There is no resume.

## Timing
- Reset values: tx_valid=0, tx_data=0, src_ready=0, busy=0, state=IDLE, rr_ptr=0, sel=0, len=0.
- src_ready, tx_valid and tx_data are functions of registers only. There is no combinational path from any input to any output.
- Grant latency is 1 cycle: a src_valid seen in IDLE gives src_ready in the next cycle.
- COLLECT accepts one byte per cycle.
- The 255th accept and the state change happen on the same edge. src_ready is low in the cycle after the 255th accept.
- tx_valid rises in the cycle after COLLECT exits. With tx_ready held at 1, the frame is len+4 consecutive bytes.
- While tx_valid & !tx_ready, tx_data holds stable and tx_valid stays 1.
- After the CRC transfer, the next grant comes 2 cycles later at the earliest: IDLE, then COLLECT.
- Sources are not checked while a frame is being sent. A source may hold src_valid indefinitely.

## Test plan
All scenarios use N_SRC=4, PREFIX=8'hAA.
- src2 sends 01,02,03 back-to-back, tx_ready=1 → tx sequence AA,02,03,01,02,03,0B; busy low 1 cycle after the CRC transfer.
- Same stimulus with tx_ready toggling 1,0,1,0… → identical byte sequence; each byte held stable through its stall cycles; no byte duplicated or lost.
- After reset, src0 and src3 valid together, 1 byte each (10 and 20) → frame AA,00,01,10,11, then AA,03,01,20,24; src_ready[3] is 0 during src0's frame.
- src1 streams 300 bytes with values 00,01,…,FF,00,…,2B:
  - First frame: AA,01,FF, bytes 00..FE, CRC 81.
  - Second frame: LEN=2D, bytes FF,00..2B.
  - src_ready[1] is low for the whole of each send phase.
- src1 sends FF,FF → CRC wraps to 01; frame AA,01,02,FF,FF,01.
- Edge cases:
  - n_rst asserted during SEND_DATA → tx_valid=0 and src_ready=0 immediately; after release a new src0 message starts with AA.
  - src_valid drops in the first COLLECT cycle → no frame; return to IDLE.
